sdr_cpu_responder: RTL and testbench
====================================

Name: sdr_cpu_responder

Overview:
- SDRAM-side responder for the CPU channel. It services the single-cycle request pulses issued by the m72 CPU bus bridge on CLK_96M (sdr_cpu_req/addr/din/wr_sel), and returns sdr_cpu_dout with a one-cycle sdr_cpu_rdy pulse.
- It translates each request into a held-until-acknowledged command on the SDRAM controller channel.
- It holds a one-word read buffer so that repeated reads of the same word (opcode prefetch re-reads, polling loops) complete without an SDRAM access.

Parameters:
- ADDR_W, 24, word-address width of sdr_cpu_addr/ram_addr (bits [24:1])
- HIT_CNT_W, 16, width of the saturating hit counter

Ports:
- CLK_96M  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- sdr_cpu_req  in  1  single-cycle request strobe from the CPU bridge
- sdr_cpu_addr  in  ADDR_W  word address, valid with sdr_cpu_req
- sdr_cpu_din  in  16  write data, valid with sdr_cpu_req
- sdr_cpu_wr_sel  in  2  byte enables; 2'b00 = read, nonzero = write of the selected bytes
- sdr_cpu_dout  out  16  read data, valid while sdr_cpu_rdy=1 and held afterwards
- sdr_cpu_rdy  out  1  one-cycle completion pulse
- ram_req  out  1  command request, level, held until ram_ack
- ram_ack  in  1  controller accepted the command
- ram_addr  out  ADDR_W  command word address
- ram_din  out  16  write data
- ram_be  out  2  byte enables
- ram_we  out  1  1 = write command
- ram_dout  in  16  read data
- ram_dout_valid  in  1  read data strobe
- cache_en  in  1  read buffer enable
- busy  out  1  request in flight (state != IDLE)
- protocol_err  out  1  sticky; request received while busy
- hit_count  out  HIT_CNT_W  saturating count of buffer hits

Behaviour:
- Reset values: sdr_cpu_rdy=0, sdr_cpu_dout=0, ram_req=0, ram_we=0, ram_be=0, ram_addr=0, ram_din=0, busy=0, protocol_err=0, hit_count=0; buffer valid=0; state=IDLE.
- Reset asserted mid-operation aborts the transaction: ram_req drops immediately and no rdy pulse is produced.
- Requests are latched in IDLE only. A sdr_cpu_req seen in any other state is dropped and sets protocol_err; it clears only on reset.
- State IDLE, read (wr_sel=00) with cache_en=1, valid=1 and tag==addr (hit):
  - stay IDLE;
  - next edge: sdr_cpu_dout=buffer data, sdr_cpu_rdy=1;
  - hit_count increments, saturating at all-ones.
- State IDLE, any other request:
  - register ram_addr=addr, ram_din=din, ram_be = (wr_sel==0 ? 2'b11 : wr_sel), ram_we=|wr_sel;
  - ram_req=1; go to ISSUE. ram_req is first visible one cycle after sdr_cpu_req.
- ISSUE: ram_req and command fields held stable until ram_ack is sampled high; at that edge ram_req<=0.
  - Write: go to DONE; rdy pulses one cycle later.
  - Read with ram_dout_valid also high at the same edge: capture immediately (same as WAIT_RD).
  - Read otherwise: go to WAIT_RD.
- WAIT_RD: on the edge sampling ram_dout_valid=1:
  - sdr_cpu_dout<=ram_dout, sdr_cpu_rdy<=1, state<=IDLE;
  - if cache_en: buffer tag<=ram_addr, data<=ram_dout, valid<=1.
  - ram_dout_valid is ignored in every other state.
- DONE: sdr_cpu_rdy<=1 for one cycle, state<=IDLE.
- Write coherency: a write whose addr equals a valid tag merges the enabled bytes of din into the buffer data at request-latch time. A write miss does not allocate.
- cache_en=0: valid is cleared on the next edge, all reads miss, and no fill occurs.
- sdr_cpu_rdy is exactly one cycle wide; exactly one pulse per accepted request.
- sdr_cpu_dout is unchanged on write completion.
- The block sees at most one request in flight; there is no queueing.

Test Plan:
- Read miss: req addr=0x000100, wr_sel=00; ram_ack 3 cycles later; ram_dout_valid with 0xBEEF 5 cycles after that -> ram_req high 1 cycle after req, low after ack; rdy pulses once with dout=0xBEEF; buffer valid.
- Read hit: repeat the read of 0x000100 -> no ram_req; rdy on the next cycle with dout=0xBEEF; hit_count=1.
- Partial write to buffered word: addr 0x000100, wr_sel=10, din=0x12xx -> ram_we=1, ram_be=10, rdy one cycle after ack; subsequent read hits with dout=0x12EF.
- Ack and data in the same cycle: read of 0x000200 with ram_ack and ram_dout_valid both high, data 0x5A5A -> rdy on the next cycle with dout=0x5A5A; no WAIT_RD stall.
- Protocol error and cache_en: req pulsed during WAIT_RD -> protocol_err=1, exactly one rdy for the original request. Drop cache_en, then re-read 0x000100 -> miss, issues ram_req.
- Async reset during ISSUE: ram_req=1, reset asserted -> ram_req=0 without a clock edge; after release, no rdy and valid=0; next request serviced normally.

Source files
------------

// File: rtl/sdr_cpu_responder.sv
// sdr_cpu_responder: services CPU bridge request pulses against the SDRAM
// controller channel and keeps a one-word read buffer so repeated reads of
// the same word complete without an SDRAM access.
// Ports:
//   CLK_96M, reset (async, active-high)
//   CPU side : sdr_cpu_req/addr/din/wr_sel in, sdr_cpu_dout/sdr_cpu_rdy out
//   RAM side : ram_req/addr/din/be/we out, ram_ack/ram_dout/ram_dout_valid in
//   Control  : cache_en in; busy, protocol_err, hit_count out
module sdr_cpu_responder #(
    parameter int ADDR_W    = 24,
    parameter int HIT_CNT_W = 16
) (
    input  logic                 CLK_96M,
    input  logic                 reset,
    input  logic                 sdr_cpu_req,
    input  logic [ADDR_W-1:0]    sdr_cpu_addr,
    input  logic [15:0]          sdr_cpu_din,
    input  logic [1:0]           sdr_cpu_wr_sel,
    output logic [15:0]          sdr_cpu_dout,
    output logic                 sdr_cpu_rdy,
    output logic                 ram_req,
    input  logic                 ram_ack,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [15:0]          ram_din,
    output logic [1:0]           ram_be,
    output logic                 ram_we,
    input  logic [15:0]          ram_dout,
    input  logic                 ram_dout_valid,
    input  logic                 cache_en,
    output logic                 busy,
    output logic                 protocol_err,
    output logic [HIT_CNT_W-1:0] hit_count
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

    state_t                state_q, state_d;
    logic                  rdy_q, rdy_d;
    logic [15:0]           dout_q, dout_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [1:0]            be_q, be_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [15:0]           din_q, din_d;
    logic                  perr_q, perr_d;
    logic [HIT_CNT_W-1:0]  hit_q, hit_d;
    logic                  valid_q, valid_d;
    logic [ADDR_W-1:0]     tag_q, tag_d;
    logic [15:0]           data_q, data_d;
    logic                  tag_match, hit, capture;

    assign tag_match = valid_q && (tag_q == sdr_cpu_addr);
    assign hit       = cache_en && tag_match && (sdr_cpu_wr_sel == 2'b00);

    always_comb begin
        state_d = state_q;
        rdy_d   = 1'b0;
        dout_d  = dout_q;
        req_d   = req_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        din_d   = din_q;
        perr_d  = perr_q;
        hit_d   = hit_q;
        valid_d = valid_q & cache_en;
        tag_d   = tag_q;
        data_d  = data_q;
        capture = 1'b0;
        if (sdr_cpu_req && state_q != IDLE)
            perr_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (sdr_cpu_req) begin
                    if (hit) begin
                        rdy_d  = 1'b1;
                        dout_d = data_q;
                        hit_d  = &hit_q ? hit_q : hit_q + 1'b1;
                    end else begin
                        addr_d  = sdr_cpu_addr;
                        din_d   = sdr_cpu_din;
                        be_d    = (sdr_cpu_wr_sel == 2'b00) ? 2'b11 : sdr_cpu_wr_sel;
                        we_d    = |sdr_cpu_wr_sel;
                        req_d   = 1'b1;
                        state_d = ISSUE;
                        // Keep the buffered word coherent with writes to it
                        if (|sdr_cpu_wr_sel && tag_match)
                            data_d = {sdr_cpu_wr_sel[1] ? sdr_cpu_din[15:8] : data_q[15:8],
                                      sdr_cpu_wr_sel[0] ? sdr_cpu_din[7:0]  : data_q[7:0]};
                    end
                end
            end
            ISSUE: begin
                if (ram_ack) begin
                    req_d   = 1'b0;
                    state_d = we_q ? DONE : WAIT_RD;
                    capture = !we_q && ram_dout_valid;
                end
            end
            WAIT_RD: capture = ram_dout_valid;
            DONE: begin
                rdy_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (capture) begin
            dout_d  = ram_dout;
            rdy_d   = 1'b1;
            state_d = IDLE;
            if (cache_en) begin
                tag_d   = addr_q;
                data_d  = ram_dout;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_96M or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            dout_q  <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            perr_q  <= 1'b0;
            hit_q   <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            dout_q  <= dout_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            perr_q  <= perr_d;
            hit_q   <= hit_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign sdr_cpu_rdy  = rdy_q;
    assign sdr_cpu_dout = dout_q;
    assign ram_req      = req_q;
    assign ram_we       = we_q;
    assign ram_be       = be_q;
    assign ram_addr     = addr_q;
    assign ram_din      = din_q;
    assign busy         = (state_q != IDLE);
    assign protocol_err = perr_q;
    assign hit_count    = hit_q;
endmodule

// File: tb/tb_sdr_cpu_responder.sv
// tb_sdr_cpu_responder: scoreboard bench for the CPU-channel SDRAM responder.
module tb_sdr_cpu_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [23:0] addr = '0;
    logic [15:0] din = '0;
    logic [1:0]  wr_sel = '0;
    logic [15:0] dout;
    logic        rdy;
    logic        ram_req;
    logic        ram_ack = 1'b0;
    logic [23:0] ram_addr;
    logic [15:0] ram_din;
    logic [1:0]  ram_be;
    logic        ram_we;
    logic [15:0] ram_dout = '0;
    logic        ram_dout_valid = 1'b0;
    logic        cache_en = 1'b1;
    logic        busy;
    logic        perr;
    logic [15:0] hit_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    sdr_cpu_responder dut (
        .CLK_96M(clk), .reset(reset),
        .sdr_cpu_req(req), .sdr_cpu_addr(addr), .sdr_cpu_din(din), .sdr_cpu_wr_sel(wr_sel),
        .sdr_cpu_dout(dout), .sdr_cpu_rdy(rdy),
        .ram_req(ram_req), .ram_ack(ram_ack), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_be(ram_be), .ram_we(ram_we), .ram_dout(ram_dout), .ram_dout_valid(ram_dout_valid),
        .cache_en(cache_en), .busy(busy), .protocol_err(perr), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rdy: got dout=%h, required no rdy", dout);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    errors++;
                    $display("FAIL rdy_dout: got %h, required %h", dout, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [23:0] a, input logic [1:0] ws, input logic [15:0] d);
        req = 1'b1; addr = a; wr_sel = ws; din = d;
        tick();
        req = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
        check("pending_rdy", exp_q.size(), 0);
    endtask

    task automatic ack_with_data(input logic [15:0] d);
        ram_ack = 1'b1; ram_dout_valid = 1'b1; ram_dout = d;
        tick();
        ram_ack = 1'b0; ram_dout_valid = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        check("rst_ram_req", ram_req, 0);
        check("rst_rdy", rdy, 0);
        check("rst_dout", dout, 0);
        check("rst_busy", busy, 0);
        check("rst_misc", {ram_we, ram_be, ram_addr, ram_din, perr, hit_count}, 0);
        reset = 1'b0;
        tick();

        // read miss
        exp_q.push_back(16'hBEEF);
        issue(24'h000100, 2'b00, 16'h0000);
        check("miss_ram_req", ram_req, 1);
        check("miss_cmd", {ram_we, ram_be, ram_addr}, {1'b0, 2'b11, 24'h000100});
        check("miss_busy", busy, 1);
        repeat (2) tick();
        ram_ack = 1'b1;
        tick();
        ram_ack = 1'b0;
        check("miss_req_drop", ram_req, 0);
        repeat (4) tick();
        check("miss_wait_busy", busy, 1);
        ram_dout_valid = 1'b1; ram_dout = 16'hBEEF;
        tick();
        ram_dout_valid = 1'b0;
        settle(3);

        // read hit
        exp_q.push_back(16'hBEEF);
        issue(24'h000100, 2'b00, 16'h0000);
        check("hit_no_req", ram_req, 0);
        check("hit_rdy", rdy, 1);
        settle(2);
        check("hit_count1", hit_count, 1);

        // partial write into the buffered word; dout unchanged on completion
        exp_q.push_back(16'hBEEF);
        issue(24'h000100, 2'b10, 16'h1234);
        check("wr_cmd", {ram_req, ram_we, ram_be, ram_din}, {1'b1, 1'b1, 2'b10, 16'h1234});
        ram_ack = 1'b1;
        tick();
        ram_ack = 1'b0;
        check("wr_rdy_not_yet", rdy, 0);
        tick();
        check("wr_rdy", rdy, 1);
        settle(2);
        exp_q.push_back(16'h12EF);
        issue(24'h000100, 2'b00, 16'h0000);
        check("merge_no_req", ram_req, 0);
        settle(2);
        check("hit_count2", hit_count, 2);

        // ack and data in the same cycle
        exp_q.push_back(16'h5A5A);
        issue(24'h000200, 2'b00, 16'h0000);
        ack_with_data(16'h5A5A);
        check("same_cycle_rdy", rdy, 1);
        check("same_cycle_idle", busy, 0);
        settle(2);

        // protocol error during WAIT_RD
        exp_q.push_back(16'hCAFE);
        issue(24'h000100, 2'b00, 16'h0000);
        check("perr_miss_req", ram_req, 1);
        ram_ack = 1'b1;
        tick();
        ram_ack = 1'b0;
        issue(24'h000300, 2'b11, 16'hFFFF);
        check("perr_set", perr, 1);
        check("perr_req_ignored", ram_req, 0);
        ram_dout_valid = 1'b1; ram_dout = 16'hCAFE;
        tick();
        ram_dout_valid = 1'b0;
        settle(3);

        // cache disabled: buffered 0x100 must miss and not refill
        cache_en = 1'b0;
        tick();
        exp_q.push_back(16'h1111);
        issue(24'h000100, 2'b00, 16'h0000);
        check("nocache_miss", ram_req, 1);
        ack_with_data(16'h1111);
        settle(2);
        cache_en = 1'b1;
        tick();
        exp_q.push_back(16'h2222);
        issue(24'h000100, 2'b00, 16'h0000);
        check("nofill_miss", ram_req, 1);
        ack_with_data(16'h2222);
        settle(2);
        check("hit_count_kept", hit_count, 2);
        check("perr_sticky", perr, 1);

        // async reset during ISSUE
        issue(24'h000400, 2'b00, 16'h0000);
        check("rst_issue_req", ram_req, 1);
        #2 reset = 1'b1;
        #1;
        check("async_req_drop", ram_req, 0);
        check("async_clear", {busy, perr, hit_count}, 0);
        tick();
        reset = 1'b0;
        settle(3);
        exp_q.push_back(16'h7777);
        issue(24'h000200, 2'b00, 16'h0000);
        check("post_rst_miss", ram_req, 1);
        ack_with_data(16'h7777);
        settle(2);
        exp_q.push_back(16'h7777);
        issue(24'h000200, 2'b00, 16'h0000);
        check("post_rst_hit", ram_req, 0);
        settle(2);
        check("post_rst_hits", hit_count, 1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("final_pending", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
